// File: rtl/sum_collector_pkg.sv
// Shared types and default sizes for the adder result collector.
package sum_collector_pkg;

  localparam int unsigned ENTRY_W       = 9;
  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_ACC_W = 16;

  typedef struct packed {
    logic       carry;
    logic [7:0] sum;
  } entry_t;

endpackage

// File: rtl/sum_fifo_storage.sv
// DEPTH-entry register array with one write port and an asynchronous read port.
module sum_fifo_storage
  import sum_collector_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  entry_t                   wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output entry_t                   rd_data
);

  entry_t mem [DEPTH];

  // Storage is intentionally unreset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sum_result_collector.sv
// Collects adder {carry, sum} results into a FIFO with valid/ready drain,
// a wrap-around accumulator of accepted results and a sticky drop flag.
module sum_result_collector
  import sum_collector_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned ACC_W = DEFAULT_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               In_sum,
  input  logic                     In_carry,
  input  logic                     In_valid,
  output logic [ENTRY_W-1:0]       Out_data,
  output logic                     Out_valid,
  input  logic                     Out_ready,
  output logic [$clog2(DEPTH):0]   Fifo_count,
  output logic                     Overflow,
  input  logic                     Clear_ovf,
  output logic [ACC_W-1:0]         Acc_value,
  input  logic                     Acc_clear
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  entry_t in_entry;
  entry_t head;
  logic   full;
  logic   empty;
  logic   pop;
  logic   push;
  logic   drop;

  assign in_entry = '{carry: In_carry, sum: In_sum};

  // Full/empty come from the occupancy count so pointers can wrap freely.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && Out_ready;
  assign push  = In_valid && (!full || pop);
  assign drop  = In_valid && full && !Out_ready;

  sum_fifo_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (push && !reset),
    .wr_addr (wr_ptr),
    .wr_data (in_entry),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);

      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      if (Acc_clear)  acc <= push ? ACC_W'(in_entry) : '0;
      else if (push)  acc <= acc + ACC_W'(in_entry);

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)           ovf <= 1'b1;
      else if (Clear_ovf) ovf <= 1'b0;
    end
  end

  assign Out_valid  = !empty;
  assign Out_data   = empty ? ENTRY_W'(0) : ENTRY_W'(head);
  assign Fifo_count = count;
  assign Overflow   = ovf;
  assign Acc_value  = acc;

endmodule

// File: tb/tb_sum_result_collector.sv
// Randomized and directed checks of sum_result_collector against a queue model.
module tb_sum_result_collector;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned ACC_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  In_sum;
  logic        In_carry;
  logic        In_valid;
  logic [8:0]  Out_data;
  logic        Out_valid;
  logic        Out_ready;
  logic [3:0]  Fifo_count;
  logic        Overflow;
  logic        Clear_ovf;
  logic [15:0] Acc_value;
  logic        Acc_clear;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  m_q[$];
  logic [15:0] m_acc;
  logic        m_ovf;

  always #5 clk = ~clk;

  sum_result_collector #(
    .DEPTH (DEPTH),
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .In_sum     (In_sum),
    .In_carry   (In_carry),
    .In_valid   (In_valid),
    .Out_data   (Out_data),
    .Out_valid  (Out_valid),
    .Out_ready  (Out_ready),
    .Fifo_count (Fifo_count),
    .Overflow   (Overflow),
    .Clear_ovf  (Clear_ovf),
    .Acc_value  (Acc_value),
    .Acc_clear  (Acc_clear)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [8:0] exp_data;
    exp_data = (m_q.size() != 0) ? m_q[0] : 9'h000;
    check("out_valid",  32'(Out_valid),  32'(m_q.size() != 0));
    check("out_data",   32'(Out_data),   32'(exp_data));
    check("fifo_count", 32'(Fifo_count), 32'(m_q.size()));
    check("overflow",   32'(Overflow),   32'(m_ovf));
    check("acc_value",  32'(Acc_value),  32'(m_acc));
  endtask

  // Drive one cycle's inputs, advance the model across the edge, then compare.
  task automatic cycle(input logic v, input logic [8:0] e, input logic rdy,
                       input logic clr_o, input logic clr_a, input logic rst);
    bit do_pop;
    bit do_push;
    bit do_drop;
    reset     = rst;
    In_valid  = v;
    In_carry  = e[8];
    In_sum    = e[7:0];
    Out_ready = rdy;
    Clear_ovf = clr_o;
    Acc_clear = clr_a;
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_acc = '0;
      m_ovf = 1'b0;
    end else begin
      do_pop  = (m_q.size() != 0) && rdy;
      do_push = v && ((m_q.size() < DEPTH) || do_pop);
      do_drop = v && (m_q.size() == DEPTH) && !rdy;
      if (do_pop)  void'(m_q.pop_front());
      if (do_push) m_q.push_back(e);
      if (clr_a)        m_acc = do_push ? 16'(e) : 16'h0000;
      else if (do_push) m_acc = m_acc + 16'(e);
      if (do_drop)    m_ovf = 1'b1;
      else if (clr_o) m_ovf = 1'b0;
    end
    #1;
    check_model();
  endtask

  initial begin
    reset = 1'b1; In_valid = 1'b0; In_sum = '0; In_carry = 1'b0;
    Out_ready = 1'b0; Clear_ovf = 1'b0; Acc_clear = 1'b0;
    m_acc = '0; m_ovf = 1'b0;
    @(negedge clk);

    cycle(1'b1, 9'h055, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_data", 32'(Out_data), 32'h0);
    cycle(1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two pushes with consumer stalled
    cycle(1'b1, 9'h005, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lat_valid", 32'(Out_valid), 32'h1);
    cycle(1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("two_count", 32'(Fifo_count), 32'd2);
    check("two_data",  32'(Out_data),   32'h005);
    check("two_acc",   32'(Acc_value),  32'h0204);

    // Fill, then a dropped push, then clear the flag
    for (int i = 0; i < 6; i++) cycle(1'b1, 9'(i + 16), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 9'h0AA, 1'b0, 1'b0, 1'b0, 1'b0);
    check("drop_ovf",   32'(Overflow),   32'h1);
    check("drop_count", 32'(Fifo_count), 32'd8);
    cycle(1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clr_ovf", 32'(Overflow), 32'h0);

    // Full with push and pop together: no drop, head advances
    cycle(1'b1, 9'h133, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fullpp_ovf",  32'(Overflow),   32'h0);
    check("fullpp_cnt",  32'(Fifo_count), 32'd8);
    check("fullpp_head", 32'(Out_data),   32'h1FF);

    // Drop coinciding with Clear_ovf leaves the flag set
    cycle(1'b1, 9'h0AB, 1'b0, 1'b1, 1'b0, 1'b0);
    check("set_wins", 32'(Overflow), 32'h1);

    // Drain to 7, then back-to-back push/pop across pointer wrap
    cycle(1'b0, 9'h000, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 9'(i * 37 + 3), 1'b1, 1'b0, 1'b0, 1'b0);
    check("wrap_count", 32'(Fifo_count), 32'd7);
    for (int i = 0; i < 8; i++) cycle(1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("drained", 32'(Out_valid), 32'h0);
    cycle(1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Build accumulator up to 16'hFFF0 then wrap
    cycle(1'b1, 9'h1FF, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 127; i++) cycle(1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 9'h070, 1'b1, 1'b0, 1'b0, 1'b0);
    check("acc_fff0", 32'(Acc_value), 32'hFFF0);
    cycle(1'b1, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);
    check("acc_wrap", 32'(Acc_value), 32'h01EF);
    cycle(1'b1, 9'h010, 1'b1, 1'b0, 1'b1, 1'b0);
    check("acc_clr_push", 32'(Acc_value), 32'h0010);
    cycle(1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("acc_clr", 32'(Acc_value), 32'h0000);

    // Mid-operation reset with count=5 and Overflow set
    for (int i = 0; i < 8; i++) cycle(1'b1, 9'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 9'h0EE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0);
    check("pre_rst_cnt", 32'(Fifo_count), 32'd5);
    cycle(1'b1, 9'h0EE, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_valid", 32'(Out_valid),  32'h0);
    check("rst_count", 32'(Fifo_count), 32'd0);
    check("rst_ovf",   32'(Overflow),   32'h0);
    check("rst_acc",   32'(Acc_value),  32'h0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
            9'($urandom),
            ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 5)  ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0,
            ($urandom_range(0, 999) < 5) ? 1'b1 : 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
